ram_cmd_arbiter: RTL and testbench
==================================

Name: ram_cmd_arbiter

Overview:
- Round-robin arbiter and command sequencer that shares the single-port command-driven RAM between NUM_REQ requesters.
- Converts each requester's simple read/write transaction into the RAM's 10-bit command stream:
  - 00 sets the write address.
  - 01 writes data.
  - 10 sets the read address.
  - 11 triggers a read.
- Collects the RAM's read data and returns it to the requester with a one-cycle ack.
- Sits between the SPI slave/debug hosts and the RAM; the RAM's own reset must be driven from the same reset event.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- RD_TIMEOUT, 4, max cycles in RD_WAIT for ram_tx_valid before an error completion (1..15).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester transaction request; held until ack.
- we  input  NUM_REQ  per-requester 1=write, 0=read; stable while req.
- addr  input  NUM_REQ*8  per-requester address, slice i = [8i+7:8i].
- wdata  input  NUM_REQ*8  per-requester write data, same slicing.
- ack  output  NUM_REQ  one-hot, one-cycle completion pulse.
- rdata  output  8  read data, valid only with a read ack.
- err  output  1  read timed out, valid with ack.
- busy  output  1  high in every state except IDLE.
- ram_din  output  10  command to RAM {op[1:0], payload[7:0]}.
- ram_rx_valid  output  1  command strobe to RAM.
- ram_dout  input  8  RAM read data.
- ram_tx_valid  input  1  RAM read-data valid.

Behaviour:
- Reset values:
  - ack=0, rdata=0, err=0, busy=0, ram_rx_valid=0, ram_din=0.
  - State IDLE.
  - Round-robin pointer last_gnt=NUM_REQ-1, so requester 0 wins first.
- Outputs are decoded from registered state and latched transaction registers only. There is no combinational path from req/addr to outputs.
- IDLE:
  - If any req is set, the winner is the first requesting index after last_gnt, cyclically.
  - Latch winner index, we, addr, wdata; set last_gnt=winner.
  - Next state: WR_ADDR if we=1, else RD_ADDR.
- WR_ADDR: ram_rx_valid=1, ram_din={00,addr}, then WR_DATA.
- WR_DATA: ram_rx_valid=1, ram_din={01,wdata}, ack[winner]=1, then IDLE.
- RD_ADDR: ram_rx_valid=1, ram_din={10,addr}. The RAM clears tx_valid here. Then RD_CMD.
- RD_CMD: ram_rx_valid=1, ram_din={11,8'h00}, timeout counter=0, then RD_WAIT.
- RD_WAIT:
  - If ram_tx_valid=1: rdata<=ram_dout, err<=0, go RD_DONE.
  - Else if counter==RD_TIMEOUT-1: rdata<=0, err<=1, go RD_DONE.
  - Else counter+1.
- RD_DONE: ack[winner]=1 with rdata/err valid, then IDLE.
- Latency from req seen in IDLE (cycle 0):
  - Write: ack in cycle 2.
  - Read: ack in cycle 4 with a nominal RAM.
  - One idle cycle between back-to-back transactions.
- Requests arriving mid-transaction wait. A requester dropping req before ack is illegal; the transaction still completes.
- Simultaneous requests: exactly one grant per IDLE visit. Strict alternation when all requesters request continuously.
- rdata holds its value until the next read completion. err holds until the next read completion.
- rst in any state: IDLE on the next cycle, with no ack and no partial command issued after the reset cycle. The RAM is reset by the same event.

Optional Feature:
- Macro: RAM_ARB_ADDR_CACHE_EN.
- Defined:
  - Keep shadow registers wr_addr_q/wr_vld and rd_addr_q/rd_vld, cleared by rst.
  - A write whose addr matches a valid wr_addr_q skips WR_ADDR and goes straight to WR_DATA; ack in cycle 1.
  - A read whose addr matches a valid rd_addr_q skips RD_ADDR; ack in cycle 3.
  - The shadow is updated whenever a 00 or 10 command is issued.
- Undefined: address commands are always issued and no shadow state exists.

Decomposition:
- Package ram_arb_pkg holds:
  - op codes OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD=2'b11;
  - state enum {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT, RD_DONE};
  - CMD_W=10.
- Sub-module rr_arbiter: the round-robin pick from a req vector and last_gnt pointer, producing a one-hot grant and index.

Test Plan:
- Req0 write addr 0x3C, wdata 0xA5 → ram_din 0x03C in cycle 1 and 0x1A5 in cycle 2, each with ram_rx_valid; ack[0] in cycle 2.
- Req1 read addr 0x3C after the write above → ram_din 0x23C then 0x300; ack[1] in cycle 4, rdata=0xA5, err=0.
- req=2'b11 continuous reads right after reset → grants 0,1,0,1; each ack one-hot and never overlapping.
- RAM model holds ram_tx_valid=0 on a read → ack after RD_TIMEOUT=4 cycles in RD_WAIT, err=1, rdata=0x00.
- rst pulsed during WR_DATA → next cycle IDLE, ram_rx_valid=0, no ack. A fresh write then completes normally, starting with a 00 command.
- With RAM_ARB_ADDR_CACHE_EN, two writes to addr 0x10 → second issues only 0x1xx and acks in cycle 1. After rst the first write again issues 0x010.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: RAM command opcodes, arbiter FSM states and the latched transaction record.
// Pure declarations; no latency or backpressure of its own.
package ram_arb_pkg;

    localparam int CMD_W = 10;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD      = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_CMD,
        RD_WAIT,
        RD_DONE
    } state_t;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    function automatic logic [CMD_W-1:0] mk_cmd(input logic [1:0] op, input logic [7:0] payload);
        return {op, payload};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester after i_last_gnt wins (zero latency).
// No backpressure: losers are expected to keep their request asserted.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_gnt,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_vld
);

    localparam int PW = IDX_W + 1;

    logic [PW-1:0] w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        w_pos = '0;
        // Walk from the farthest candidate to the nearest so the nearest requester wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_pos = {1'b0, i_last_gnt} + PW'(k);
            if (w_pos >= PW'(NUM_REQ)) begin
                w_pos = w_pos - PW'(NUM_REQ);
            end
            if (i_req[w_pos[IDX_W-1:0]]) begin
                o_gnt                    = '0;
                o_gnt[w_pos[IDX_W-1:0]]  = 1'b1;
                o_idx                    = w_pos[IDX_W-1:0];
                o_vld                    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter: round-robin sharer of the command RAM; write ack 2 cycles after grant, read ack 4 (+ RAM wait, bounded by RD_TIMEOUT).
// Losers hold req; one transaction in flight. RAM_ARB_ADDR_CACHE_EN skips repeated address commands (one cycle less).
module ram_cmd_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int RD_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   we,
    input  logic [NUM_REQ*8-1:0] addr,
    input  logic [NUM_REQ*8-1:0] wdata,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           rdata,
    output logic                 err,
    output logic                 busy,
    output logic [CMD_W-1:0]     ram_din,
    output logic                 ram_rx_valid,
    input  logic [7:0]           ram_dout,
    input  logic                 ram_tx_valid
);

    localparam int         IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] TMO_LAST = 4'(RD_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   r_last_gnt;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    txn_t               r_txn;
    txn_t               w_txn;
    logic [3:0]         r_cnt;
    logic [7:0]         r_rdata;
    logic               r_err;
    logic               w_wr_hit;
    logic               w_rd_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req      (req),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_gnt),
        .o_idx      (w_idx),
        .o_vld      (w_any)
    );

    always_comb begin
        w_txn = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_txn = '{we: we[i], addr: addr[8*i +: 8], wdata: wdata[8*i +: 8]};
            end
        end
    end

`ifdef RAM_ARB_ADDR_CACHE_EN
    logic [7:0] r_wr_addr_q;
    logic [7:0] r_rd_addr_q;
    logic       r_wr_vld;
    logic       r_rd_vld;

    // Mirrors the RAM's own address pointers so a repeated address need not be re-sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr_q <= '0;
            r_wr_vld    <= 1'b0;
            r_rd_addr_q <= '0;
            r_rd_vld    <= 1'b0;
        end else begin
            if (r_state == WR_ADDR) begin
                r_wr_addr_q <= r_txn.addr;
                r_wr_vld    <= 1'b1;
            end
            if (r_state == RD_ADDR) begin
                r_rd_addr_q <= r_txn.addr;
                r_rd_vld    <= 1'b1;
            end
        end
    end

    assign w_wr_hit = r_wr_vld && (r_wr_addr_q == w_txn.addr);
    assign w_rd_hit = r_rd_vld && (r_rd_addr_q == w_txn.addr);
`else
    assign w_wr_hit = 1'b0;
    assign w_rd_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    if (w_txn.we) begin
                        w_state_nxt = w_wr_hit ? WR_DATA : WR_ADDR;
                    end else begin
                        w_state_nxt = w_rd_hit ? RD_CMD : RD_ADDR;
                    end
                end
            end
            WR_ADDR: w_state_nxt = WR_DATA;
            WR_DATA: w_state_nxt = IDLE;
            RD_ADDR: w_state_nxt = RD_CMD;
            RD_CMD:  w_state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (ram_tx_valid || (r_cnt == TMO_LAST)) begin
                    w_state_nxt = RD_DONE;
                end
            end
            RD_DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Everything the RAM and requesters see is decoded from registered state only.
    always_comb begin
        ram_rx_valid = 1'b0;
        ram_din      = '0;
        ack          = '0;
        case (r_state)
            WR_ADDR: begin
                ram_rx_valid = 1'b1;
                ram_din      = mk_cmd(OP_WR_ADDR, r_txn.addr);
            end
            WR_DATA: begin
                ram_rx_valid = 1'b1;
                ram_din      = mk_cmd(OP_WR_DATA, r_txn.wdata);
                ack          = r_gnt;
            end
            RD_ADDR: begin
                ram_rx_valid = 1'b1;
                ram_din      = mk_cmd(OP_RD_ADDR, r_txn.addr);
            end
            RD_CMD: begin
                ram_rx_valid = 1'b1;
                ram_din      = mk_cmd(OP_RD, 8'h00);
            end
            RD_DONE: ack = r_gnt;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last_gnt <= IDX_W'(NUM_REQ - 1);
            r_gnt      <= '0;
            r_txn      <= '0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt      <= w_gnt;
                        r_last_gnt <= w_idx;
                        r_txn      <= w_txn;
                    end
                end
                RD_CMD: r_cnt <= '0;
                RD_WAIT: begin
                    if (ram_tx_valid) begin
                        r_rdata <= ram_dout;
                        r_err   <= 1'b0;
                    end else if (r_cnt == TMO_LAST) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata = r_rdata;
    assign err   = r_err;
    assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Bench for ram_cmd_arbiter: directed scenarios plus random requesters against a transaction-level timing model and a command-driven RAM model.
module tb_ram_cmd_arbiter;

    localparam int NR  = 2;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR-1:0] we;
    logic [NR*8-1:0] addr;
    logic [NR*8-1:0] wdata;
    logic [NR-1:0] ack;
    logic [7:0]    rdata;
    logic          err;
    logic          busy;
    logic [9:0]    ram_din;
    logic          ram_rx_valid;
    logic [7:0]    ram_dout;
    logic          ram_tx_valid;

    ram_cmd_arbiter #(.NUM_REQ(NR), .RD_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .ack          (ack),
        .rdata        (rdata),
        .err          (err),
        .busy         (busy),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: observed 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // requesters
    bit   [NR-1:0] pend;
    bit   [NR-1:0] p_we;
    logic [7:0]    p_addr [NR];
    logic [7:0]    p_wd   [NR];

    // transaction-level reference: one job at a time, offsets counted from its grant cycle
    bit         m_act;
    int         m_c0, m_win, m_last, m_skip;
    bit         m_we, m_stall;
    logic [7:0] m_a, m_w;
    logic [7:0] exp_mem [256];
    logic [7:0] exp_rdata;
    bit         exp_err;
    int         cyc, n_acks;
    bit         rand_mode, repeat_mode, force_stall;
`ifdef RAM_ARB_ADDR_CACHE_EN
    bit         sh_wv, sh_rv;
    logic [7:0] sh_wa, sh_ra;
`endif

    // command RAM
    logic [7:0] ram_mem [256];
    logic [7:0] ram_wa, ram_ra;
    bit         ram_stall;

    task automatic tick(input bit do_rst);
        logic [9:0]    e_din;
        logic [NR-1:0] e_ack;
        bit            e_rxv, idle_now, found;
        int            e, ackd, c;
        @(negedge clk);
        cyc++;
        e_din = '0; e_rxv = 0; e_ack = '0; e = 0; ackd = -1;
        if (m_act) begin
            e = cyc - m_c0 + m_skip;
            if (m_we) begin
                ackd = 2;
                if (e == 1) begin e_rxv = 1; e_din = {2'b00, m_a}; end
                else if (e == 2) begin e_rxv = 1; e_din = {2'b01, m_w}; end
            end else begin
                ackd = m_stall ? 3 + TMO : 4;
                if (e == 1) begin e_rxv = 1; e_din = {2'b10, m_a}; end
                else if (e == 2) begin e_rxv = 1; e_din = {2'b11, 8'h00}; end
            end
            if (e == ackd) begin
                e_ack = NR'(1) << m_win;
                if (!m_we) begin
                    exp_rdata = m_stall ? 8'h00 : exp_mem[m_a];
                    exp_err   = m_stall;
                end
            end
        end
        chk("ack",          32'(ack),          32'(e_ack));
        chk("busy",         32'(busy),         32'(m_act));
        chk("ram_rx_valid", 32'(ram_rx_valid), 32'(e_rxv));
        chk("ram_din",      32'(ram_din),      32'(e_din));
        chk("rdata",        32'(rdata),        32'(exp_rdata));
        chk("err",          32'(err),          32'(exp_err));

        if (ram_rx_valid === 1'b1) begin
            case (ram_din[9:8])
                2'b00: ram_wa = ram_din[7:0];
                2'b01: ram_mem[ram_wa] = ram_din[7:0];
                2'b10: begin ram_ra = ram_din[7:0]; ram_tx_valid = 1'b0; end
                default: begin
                    if (ram_stall) ram_tx_valid = 1'b0;
                    else begin ram_dout = ram_mem[ram_ra]; ram_tx_valid = 1'b1; end
                end
            endcase
        end

        idle_now = !m_act;
        if (m_act && e == ackd) begin
            m_act = 0;
            pend[m_win] = repeat_mode;
            n_acks++;
            if (m_we) exp_mem[m_a] = m_w;
        end

        if (do_rst) begin
            rst = 1'b1;
            pend = '0; m_act = 0; m_last = NR - 1;
            exp_rdata = 8'h00; exp_err = 0;
            ram_wa = 8'h00; ram_ra = 8'h00; ram_tx_valid = 1'b0; ram_dout = 8'h00;
`ifdef RAM_ARB_ADDR_CACHE_EN
            sh_wv = 0; sh_rv = 0;
`endif
        end else begin
            rst = 1'b0;
        end

        if (rand_mode && !do_rst) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]   = 1'b1;
                    p_we[i]   = 1'($urandom_range(0, 1));
                    p_addr[i] = 8'($urandom_range(0, 7));
                    p_wd[i]   = 8'($urandom);
                end
            end
        end
        for (int i = 0; i < NR; i++) begin
            req[i]          = pend[i];
            we[i]           = p_we[i];
            addr[8*i +: 8]  = p_addr[i];
            wdata[8*i +: 8] = p_wd[i];
        end

        if (idle_now && !do_rst && pend != '0) begin
            found = 0;
            for (int j = 1; j <= NR; j++) begin
                c = (m_last + j) % NR;
                if (!found && pend[c]) begin found = 1; m_win = c; end
            end
            m_last  = m_win;
            m_act   = 1;
            m_c0    = cyc;
            m_we    = p_we[m_win];
            m_a     = p_addr[m_win];
            m_w     = p_wd[m_win];
            m_stall = !m_we && (force_stall || (rand_mode && $urandom_range(0, 4) == 0));
            ram_stall = m_stall;
            m_skip  = 0;
`ifdef RAM_ARB_ADDR_CACHE_EN
            if (m_we) begin
                if (sh_wv && sh_wa == m_a) m_skip = 1;
                else begin sh_wv = 1; sh_wa = m_a; end
            end else begin
                if (sh_rv && sh_ra == m_a) m_skip = 1;
                else begin sh_rv = 1; sh_ra = m_a; end
            end
`endif
        end
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 0;
        for (int n = 0; n < budget; n++) begin
            if (!m_act && pend == '0) begin done = 1; break; end
            tick(0);
        end
        if (!m_act && pend == '0) done = 1;
        chk("drain_in_budget", 32'(done), 32'd1);
    endtask

    task automatic run_to_offset(input int target);
        bit hit;
        hit = 0;
        for (int n = 0; n < 50; n++) begin
            if (m_act && (cyc + 1 - m_c0 + m_skip) == target) begin hit = 1; break; end
            tick(0);
        end
        chk("reset_point_reached", 32'(hit), 32'd1);
    endtask

    task automatic post(input int i, input bit w, input logic [7:0] a, input logic [7:0] d);
        pend[i] = 1'b1; p_we[i] = w; p_addr[i] = a; p_wd[i] = d;
    endtask

    initial begin
        int base;
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        ram_dout = 8'h00; ram_tx_valid = 1'b0; ram_stall = 0;
        ram_wa = 8'h00; ram_ra = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'(i * 7 + 3);
            exp_mem[i] = 8'(i * 7 + 3);
        end
        for (int i = 0; i < NR; i++) begin p_addr[i] = 8'h00; p_wd[i] = 8'h00; end
        pend = '0; p_we = '0; m_act = 0; m_last = NR - 1; m_skip = 0;
        exp_rdata = 8'h00; exp_err = 0; cyc = 0; n_acks = 0;
        rand_mode = 0; repeat_mode = 0; force_stall = 0;

        @(posedge clk);
        tick(1);
        tick(1);

        // write then read back through the other requester
        post(0, 1'b1, 8'h3C, 8'hA5);
        drain(40);
        post(1, 1'b0, 8'h3C, 8'h00);
        drain(40);
        chk("readback_3C", 32'(rdata), 32'h0000_00A5);

        // both requesters reading continuously straight after reset
        tick(1);
        post(0, 1'b0, 8'h05, 8'h00);
        post(1, 1'b0, 8'h3C, 8'h00);
        repeat_mode = 1;
        base = n_acks;
        for (int n = 0; n < 60 && n_acks < base + 4; n++) tick(0);
        chk("alternating_acks", 32'(n_acks - base), 32'd4);
        repeat_mode = 0;
        drain(40);

        // RAM never answers
        force_stall = 1;
        post(0, 1'b0, 8'h3C, 8'h00);
        drain(40);
        chk("timeout_err", 32'(err), 32'd1);
        force_stall = 0;

        // reset in the data phase, then in the address phase, each followed by a clean write
        post(0, 1'b1, 8'h55, 8'h66);
        run_to_offset(2);
        tick(1);
        post(1, 1'b1, 8'h55, 8'h77);
        drain(40);
        post(0, 1'b1, 8'h21, 8'h99);
        run_to_offset(1);
        tick(1);
        post(0, 1'b1, 8'h21, 8'h98);
        drain(40);

        // repeated write address, across a reset
        post(0, 1'b1, 8'h10, 8'h01);
        drain(40);
        post(0, 1'b1, 8'h10, 8'h02);
        drain(40);
        tick(1);
        post(1, 1'b1, 8'h10, 8'h03);
        drain(40);
        post(0, 1'b0, 8'h10, 8'h00);
        drain(40);

        rand_mode = 1;
        for (int n = 0; n < 1500; n++) tick($urandom_range(0, 199) == 0);
        rand_mode = 0;
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
